// File: rtl/gf180mcu_osu_sc_gp9t3v3__rrarb4_1.sv
// ----------------------------------------------------------------------------
// gf180mcu_osu_sc_gp9t3v3__rrarb4_1
//
// Round-robin arbiter cell model. It shares one downstream resource among N
// requesters. Each grant line drives one input of an AND2-gated bus or enable
// path.
//
// Grants are registered and one-hot. An owner keeps the grant until it drops
// its request, with one exception: if it holds for MAXHOLD cycles while
// another request is pending, the grant is handed to the next requester.
//
// Ports
//   CLK   in   1  clock, rising edge
//   RST   in   1  synchronous active-high reset
//   REQ   in   N  request vector, REQ[i]=1 -> requester i wants the resource
//   GNT   out  N  registered one-hot (or zero) grant vector
//   GV    out  1  grant valid, OR of GNT
//   GIDX  out  W  index of the granted requester, 0 when GV=0
// ----------------------------------------------------------------------------
module gf180mcu_osu_sc_gp9t3v3__rrarb4_1 #(
  parameter int unsigned N       = 4,
  parameter int unsigned W       = 2,
  parameter int unsigned MAXHOLD = 15
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic [N-1:0] REQ,
  output logic [N-1:0] GNT,
  output logic         GV,
  output logic [W-1:0] GIDX
);

  if (N < 2 || N > 8) begin : g_bad_n
    $error("rrarb4: N must be in 2..8");
  end
  if (W != $clog2(N)) begin : g_bad_w
    $error("rrarb4: W must equal ceil(log2(N))");
  end

  localparam int unsigned CntW = (MAXHOLD > 1) ? $clog2(MAXHOLD) : 1;
  localparam bit HoldEn = (MAXHOLD != 0);
  localparam logic [CntW-1:0] CntLast = CntW'((MAXHOLD > 0) ? MAXHOLD - 1 : 0);
  localparam logic [N-1:0] OneN = {{(N-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e         state_q, state_d;
  logic [N-1:0]   gnt_q, gnt_d;
  logic [W-1:0]   ptr_q, ptr_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic [N-1:0]   others;
  logic           owner_req;
  logic [W-1:0]   pick_all;
  logic [W-1:0]   pick_oth;

  // Return the first set bit of mask, scanning circularly from start.
  // The caller only uses the result when mask is non-zero.
  function automatic logic [W-1:0] rr_pick(input logic [N-1:0] mask,
                                           input logic [W-1:0] start);
    logic [W-1:0] sel;
    logic         found;
    logic [W:0]   idx;
    sel   = '0;
    found = 1'b0;
    for (int j = 0; j < int'(N); j++) begin
      idx = {1'b0, start} + (W+1)'(j);
      if (idx >= (W+1)'(N)) idx = idx - (W+1)'(N);
      if (!found && mask[idx[W-1:0]]) begin
        found = 1'b1;
        sel   = idx[W-1:0];
      end
    end
    return sel;
  endfunction

  // (idx + 1) mod N
  function automatic logic [W-1:0] rr_inc(input logic [W-1:0] idx);
    logic [W:0] nxt;
    nxt = {1'b0, idx} + 1'b1;
    if (nxt >= (W+1)'(N)) nxt = '0;
    return nxt[W-1:0];
  endfunction

  // State register
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= StIdle;
      gnt_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    // Requests other than the current owner's; equal to REQ while idle.
    others    = REQ & ~gnt_q;
    owner_req = |(REQ & gnt_q);
    pick_all  = rr_pick(REQ, ptr_q);
    pick_oth  = rr_pick(others, ptr_q);

    unique case (state_q)
      StIdle: begin
        if (|REQ) begin
          state_d = StBusy;
          gnt_d   = OneN << pick_all;
          ptr_d   = rr_inc(pick_all);
          cnt_d   = '0;
        end
      end
      StBusy: begin
        if (!owner_req) begin
          // Release: hand over in the same edge, no bubble cycle.
          if (|others) begin
            gnt_d = OneN << pick_oth;
            ptr_d = rr_inc(pick_oth);
            cnt_d = '0;
          end else begin
            state_d = StIdle;
            gnt_d   = '0;
            cnt_d   = '0;
          end
        end else if (HoldEn && (cnt_q == CntLast) && (|others)) begin
          // Forced handover; the owner is excluded from this scan.
          gnt_d = OneN << pick_oth;
          ptr_d = rr_inc(pick_oth);
          cnt_d = '0;
        end else if (HoldEn && (|others)) begin
          // Only counts under contention, and never past CntLast, so a sole
          // holder keeps the grant forever without wrapping the counter.
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
        gnt_d   = '0;
      end
    endcase
  end

  // Outputs, all derived from the registered grant.
  always_comb begin
    GNT  = gnt_q;
    GV   = |gnt_q;
    GIDX = '0;
    for (int i = 0; i < int'(N); i++) begin
      if (gnt_q[i]) GIDX = GIDX | W'(i);
    end
  end

endmodule

// File: tb/tb_gf180mcu_osu_sc_gp9t3v3__rrarb4_1.sv
module tb_gf180mcu_osu_sc_gp9t3v3__rrarb4_1;

  localparam int N       = 4;
  localparam int W       = 2;
  localparam int MAXHOLD = 15;

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic [N-1:0] REQ = '0;
  logic [N-1:0] GNT;
  logic         GV;
  logic [W-1:0] GIDX;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  int m_own = -1;
  int m_ptr = 0;
  int m_cnt = 0;

  logic [N-1:0] exp_q[$];

  gf180mcu_osu_sc_gp9t3v3__rrarb4_1 #(
    .N      (N),
    .W      (W),
    .MAXHOLD(MAXHOLD)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .REQ (REQ),
    .GNT (GNT),
    .GV  (GV),
    .GIDX(GIDX)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int scan(input logic [N-1:0] mask, input int start);
    for (int j = 0; j < N; j++) begin
      if (mask[(start + j) % N]) return (start + j) % N;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] model_gnt();
    logic [N-1:0] g;
    g = '0;
    if (m_own >= 0) g[m_own] = 1'b1;
    return g;
  endfunction

  task automatic model_step(input logic rst, input logic [N-1:0] req);
    logic [N-1:0] oth;
    int p;
    if (rst) begin
      m_own = -1; m_ptr = 0; m_cnt = 0;
    end else if (m_own < 0) begin
      p = scan(req, m_ptr);
      if (p >= 0) begin
        m_own = p; m_ptr = (p + 1) % N; m_cnt = 0;
      end
    end else begin
      oth = req;
      oth[m_own] = 1'b0;
      if (!req[m_own]) begin
        p = scan(oth, m_ptr);
        m_cnt = 0;
        if (p >= 0) begin
          m_own = p; m_ptr = (p + 1) % N;
        end else begin
          m_own = -1;
        end
      end else if (MAXHOLD != 0 && m_cnt == MAXHOLD - 1 && oth != 0) begin
        p = scan(oth, m_ptr);
        m_own = p; m_ptr = (p + 1) % N; m_cnt = 0;
      end else if (MAXHOLD != 0 && oth != 0) begin
        m_cnt++;
      end
    end
  endtask

  // Drive one cycle, push the model's prediction, then compare after the edge.
  task automatic cycle(input logic rst, input logic [N-1:0] req);
    logic [N-1:0] e;
    int idx;
    RST = rst;
    REQ = req;
    model_step(rst, req);
    exp_q.push_back(model_gnt());
    @(posedge CLK);
    #1;
    e = exp_q.pop_front();
    idx = 0;
    for (int i = 0; i < N; i++) if (e[i]) idx = i;
    check("gnt", 8'(GNT), 8'(e));
    check("gv", 8'(GV), 8'(|e));
    check("gidx", 8'(GIDX), 8'(idx));
    check("onehot0", 8'($onehot0(GNT)), 8'd1);
  endtask

  initial begin
    logic [N-1:0] r;
    logic [N-1:0] rr_seq[4];
    rr_seq[0] = 4'b0010; rr_seq[1] = 4'b0100; rr_seq[2] = 4'b1000; rr_seq[3] = 4'b0001;

    // Reset with all requesting, then contention
    cycle(1'b1, 4'b1111);
    cycle(1'b1, 4'b1111);
    check("plan_rst_gnt", 8'(GNT), 8'd0);
    check("plan_rst_gv", 8'(GV), 8'd0);
    cycle(1'b0, 4'b1111);
    check("plan_first_gnt", 8'(GNT), 8'b0001);
    check("plan_first_gidx", 8'(GIDX), 8'd0);

    // Round-robin release: owner drops its request each cycle
    for (int i = 0; i < 4; i++) begin
      r = 4'b1111 & ~model_gnt();
      cycle(1'b0, r);
      check("plan_rr", 8'(GNT), 8'(rr_seq[i]));
    end

    // Hold limit with two constant requesters
    cycle(1'b1, 4'b0000);
    for (int i = 1; i <= 45; i++) begin
      cycle(1'b0, 4'b0011);
      if (i == 15 || i == 31) check("plan_hold_a", 8'(GNT), 8'b0001);
      if (i == 16 || i == 30) check("plan_hold_b", 8'(GNT), 8'b0010);
    end

    // Sole holder, then a late contender
    cycle(1'b1, 4'b0000);
    for (int i = 0; i < 100; i++) cycle(1'b0, 4'b0100);
    check("plan_sole", 8'(GNT), 8'b0100);
    for (int i = 1; i <= 15; i++) begin
      cycle(1'b0, 4'b0101);
      if (i == 14) check("plan_sole_keep", 8'(GNT), 8'b0100);
      if (i == 15) check("plan_sole_hand", 8'(GNT), 8'b0001);
    end

    // Reset mid-grant
    cycle(1'b1, 4'b0000);
    cycle(1'b0, 4'b1000);
    check("plan_mid_gnt", 8'(GNT), 8'b1000);
    cycle(1'b1, 4'b1000);
    check("plan_mid_rst", 8'(GNT), 8'd0);
    cycle(1'b0, 4'b1001);
    check("plan_mid_ptr", 8'(GNT), 8'b0001);

    // Idle and wake
    cycle(1'b0, 4'b0000);
    check("plan_idle_gv", 8'(GV), 8'd0);
    check("plan_idle_gidx", 8'(GIDX), 8'd0);
    cycle(1'b0, 4'b0100);
    check("plan_wake", 8'(GNT), 8'b0100);
    cycle(1'b0, 4'b0000);
    check("plan_drop", 8'(GNT), 8'd0);
    cycle(1'b0, 4'b0000);

    // Random traffic with occasional resets
    for (int i = 0; i < 400; i++) begin
      r = 4'($urandom_range(0, 15));
      if (i % 3 != 0) r = r | model_gnt(); // favour long holds
      cycle(($urandom_range(0, 59) == 0), r);
    end

    check("sb_empty", 8'(exp_q.size()), 8'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
